// File: rtl/attn_pkg.sv
// Shared types and default sizes for the attention output collector.
package attn_pkg;

  localparam int DEF_D_W  = 8;
  localparam int DEF_SA_R = 16;
  localparam int DEF_SA_C = 16;
  localparam int DEF_DIM  = 16;
  localparam int DEF_D_K  = 128;

  typedef logic [DEF_D_W-1:0] elem_t;
  typedef elem_t [0:DEF_SA_R-1][0:DEF_SA_C-1] tile_t;
  typedef elem_t [0:DEF_D_K-1] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/attn_tile_buf.sv
// DIM x D_K element store: whole-tile column-group write, one-row read.
// Contents are intentionally not reset; the FSM only exposes rows after a full fill.
module attn_tile_buf #(
  parameter int D_W   = 8,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int D_K   = 128,
  parameter int TILES = D_K / SA_C,
  parameter int TCW   = $clog2(TILES + 1),
  parameter int RIW   = $clog2(SA_R)
) (
  input  logic                                 i_clk,
  input  logic                                 i_wr_en,
  input  logic [TCW-1:0]                       i_wr_sel,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]   i_wr_tile,
  input  logic [RIW-1:0]                       i_rd_sel,
  output logic [0:D_K-1][D_W-1:0]              o_rd_row
);

  logic [0:SA_R-1][0:D_K-1][D_W-1:0] r_mem;

  // Write the incoming tile into the column group chosen by the tile counter.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int t = 0; t < TILES; t++) begin
        if (i_wr_sel == TCW'(t)) begin
          for (int r = 0; r < SA_R; r++) begin
            for (int c = 0; c < SA_C; c++) begin
              r_mem[r][t*SA_C + c] <= i_wr_tile[r][c];
            end
          end
        end
      end
    end
  end

  assign o_rd_row = r_mem[i_rd_sel];

endmodule

// File: rtl/attn_out_collector.sv
// Collects D_K/SA_C attention output tiles into one head result and streams
// it out row by row over valid/ready. Single buffer: tiles landing during
// the drain are dropped and flagged on O_OVF.
module attn_out_collector
  import attn_pkg::*;
#(
  parameter int D_W  = DEF_D_W,
  parameter int SA_R = DEF_SA_R,   // must equal DIM
  parameter int SA_C = DEF_SA_C,
  parameter int DIM  = DEF_DIM,
  parameter int D_K  = DEF_D_K     // must be a multiple of SA_C
) (
  input  logic                               I_CLK,
  input  logic                               I_ASYN_RSTN,
  input  logic                               I_SYNC_RSTN,
  input  logic                               I_HEAD_START,
  input  logic                               I_DATA_VLD,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0] I_ATT_DATA,
  input  logic                               I_ROW_RDY,
  output logic                               O_ROW_VLD,
  output logic [0:D_K-1][D_W-1:0]            O_ROW_DATA,
  output logic [$clog2(DIM)-1:0]             O_ROW_IDX,
  output logic                               O_ROW_LAST,
  output logic                               O_BUSY,
  output logic                               O_DONE,
  output logic                               O_OVF
);

  localparam int TILES = D_K / SA_C;
  localparam int TCW   = $clog2(TILES + 1);
  localparam int RIW   = $clog2(DIM);
  localparam logic [TCW-1:0] LAST_TILE = TCW'(TILES - 1);
  localparam logic [RIW-1:0] LAST_ROW  = RIW'(DIM - 1);

  state_t           r_state;
  logic [TCW-1:0]   r_tile_cnt;
  logic [RIW-1:0]   r_row_cnt;
  logic             r_done;
  logic             r_ovf;

  logic             w_drain;
  logic             w_wr_en;
  logic [0:D_K-1][D_W-1:0] w_rd_row;

  assign w_drain = (r_state == DRAIN);
  // A tile is stored only when nothing higher-priority is happening this cycle.
  assign w_wr_en = I_DATA_VLD && I_SYNC_RSTN && !I_HEAD_START && !w_drain;

  attn_tile_buf #(
    .D_W   (D_W),
    .SA_R  (SA_R),
    .SA_C  (SA_C),
    .D_K   (D_K),
    .TILES (TILES),
    .TCW   (TCW),
    .RIW   (RIW)
  ) u_buf (
    .i_clk     (I_CLK),
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (r_tile_cnt),
    .i_wr_tile (I_ATT_DATA),
    .i_rd_sel  (r_row_cnt),
    .o_rd_row  (w_rd_row)
  );

  // Fill/drain FSM; clear > head start > normal operation.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      r_state    <= IDLE;
      r_tile_cnt <= '0;
      r_row_cnt  <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (!I_SYNC_RSTN || I_HEAD_START) begin
      r_state    <= IDLE;
      r_tile_cnt <= '0;
      r_row_cnt  <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (I_DATA_VLD) begin
            r_tile_cnt <= TCW'(1);
            r_row_cnt  <= '0;
            r_state    <= (TILES == 1) ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (I_DATA_VLD) begin
            r_tile_cnt <= r_tile_cnt + TCW'(1);
            if (r_tile_cnt == LAST_TILE) begin
              r_state   <= DRAIN;
              r_row_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          // No room for a new tile until the current head has left.
          if (I_DATA_VLD) r_ovf <= 1'b1;
          if (I_ROW_RDY) begin
            if (r_row_cnt == LAST_ROW) begin
              r_state    <= IDLE;
              r_tile_cnt <= '0;
              r_row_cnt  <= '0;
              r_done     <= 1'b1;
            end else begin
              r_row_cnt <= r_row_cnt + RIW'(1);
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tile_cnt <= '0;
          r_row_cnt  <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state so they are 0 outside DRAIN.
  assign O_ROW_VLD  = w_drain;
  assign O_ROW_DATA = w_drain ? w_rd_row : '0;
  assign O_ROW_IDX  = w_drain ? r_row_cnt : '0;
  assign O_ROW_LAST = w_drain && (r_row_cnt == LAST_ROW);
  assign O_BUSY     = (r_state != IDLE);
  assign O_DONE     = r_done;
  assign O_OVF      = r_ovf;

endmodule

// File: tb/tb_attn_out_collector.sv
// Directed bench for attn_out_collector: table of fill/drain scenarios plus
// hand-written abort, sync-clear and async-reset sequences.
module tb_attn_out_collector;
  import attn_pkg::*;

  localparam int NT  = 8;
  localparam int DIM = 16;
  localparam int DK  = 128;

  logic        clk = 1'b0;
  logic        arst_n, srst_n, head, dvld, rdy;
  tile_t       att;
  logic        o_vld, o_last, o_busy, o_done, o_ovf;
  row_t        o_data;
  logic [3:0]  o_idx;

  int n_chk = 0;
  int n_err = 0;

  attn_out_collector dut (
    .I_CLK        (clk),
    .I_ASYN_RSTN  (arst_n),
    .I_SYNC_RSTN  (srst_n),
    .I_HEAD_START (head),
    .I_DATA_VLD   (dvld),
    .I_ATT_DATA   (att),
    .I_ROW_RDY    (rdy),
    .O_ROW_VLD    (o_vld),
    .O_ROW_DATA   (o_data),
    .O_ROW_IDX    (o_idx),
    .O_ROW_LAST   (o_last),
    .O_BUSY       (o_busy),
    .O_DONE       (o_done),
    .O_OVF        (o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;      // tile pattern id
    int gap;      // cycles between tile pulses
    int mode;     // 0: ready always, 1: ready 1,0,0 repeating
    int ovf_row;  // row at which a stray tile is injected, -1 none
    bit inj_rdy;  // ready value required at injection
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // pat0: t*16+c, pat1: row number, pat2: 255-(t*16+c), pat3: junk, pat4: all zero
  function automatic tile_t mk_tile(input int pat, input int t);
    tile_t x;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (pat)
          0: x[r][c] = 8'(t*16 + c);
          1: x[r][c] = 8'(r);
          2: x[r][c] = 8'(255 - (t*16 + c));
          3: x[r][c] = 8'hA5;
          default: x[r][c] = 8'h00;
        endcase
    return x;
  endfunction

  // Expected element j of assembled row r.
  function automatic logic [7:0] exp_el(input int pat, input int r, input int j);
    case (pat)
      0: return 8'(j);
      1: return 8'(r);
      2: return 8'(255 - j);
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk_row(input string nm, input int pat, input int r);
    int bad = -1;
    for (int j = DK-1; j >= 0; j--)
      if (o_data[j] != exp_el(pat, r, j)) bad = j;
    n_chk++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s row %0d elem %0d got %0d expected %0d at %0t",
               nm, r, bad, o_data[bad], exp_el(pat, r, bad), $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_vld"},  o_vld,  0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_ovf"},  o_ovf,  0);
    chk({nm, "_idx"},  o_idx,  0);
    chk({nm, "_last"}, o_last, 0);
    chk_row({nm, "_data"}, 4, 0);
  endtask

  task automatic fill(input int pat, input int gap, input int n);
    rdy = 1'b0;
    for (int t = 0; t < n; t++) begin
      att  = mk_tile(pat, t);
      dvld = 1'b1;
      tick();
      dvld = 1'b0;
      chk("fill_busy", o_busy, 1);
      chk("fill_vld", o_vld, (t == NT-1) ? 1 : 0);
      if (t < n-1) repeat (gap-1) tick();
    end
  endtask

  task automatic rdy_of(input int mode, input int k, output logic v);
    v = (mode == 0) ? 1'b1 : ((k % 3) == 0);
  endtask

  task automatic drain(input int pat, input int mode, input int ovf_row, input bit inj_rdy);
    int hs = 0;
    int k  = 0;
    bit inj = 0;
    bit exp_ovf = 0;
    while (hs < DIM && k < 200) begin
      rdy_of(mode, k, rdy);
      if (ovf_row >= 0 && !inj && hs == ovf_row && rdy == inj_rdy) begin
        att  = mk_tile(3, 0);
        dvld = 1'b1;
        inj  = 1;
      end
      @(negedge clk);
      chk("drn_vld",  o_vld,  1);
      chk("drn_idx",  o_idx,  hs);
      chk("drn_last", o_last, (hs == DIM-1) ? 1 : 0);
      chk("drn_done", o_done, 0);
      chk("drn_busy", o_busy, 1);
      chk("drn_ovf",  o_ovf,  exp_ovf);
      chk_row("drn_data", pat, hs);
      if (rdy) hs++;
      tick();
      dvld = 1'b0;
      if (inj) exp_ovf = 1;
      k++;
    end
    chk("drn_timeout", (k < 200) ? 1 : 0, 1);
    rdy = 1'b1;
    chk("end_vld",  o_vld,  0);
    chk("end_done", o_done, 1);
    chk("end_busy", o_busy, 0);
    chk("end_ovf",  o_ovf,  exp_ovf);
    tick();
    chk("end_done2", o_done, 0);
    chk("end_ovf2",  o_ovf,  exp_ovf);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{pat:0, gap:3, mode:0, ovf_row:-1, inj_rdy:1'b0};
    vecs[1] = '{pat:1, gap:3, mode:1, ovf_row:-1, inj_rdy:1'b0};
    vecs[2] = '{pat:1, gap:3, mode:1, ovf_row:3,  inj_rdy:1'b0};
    vecs[3] = '{pat:2, gap:1, mode:0, ovf_row:15, inj_rdy:1'b1};

    arst_n = 1'b0; srst_n = 1'b1; head = 1'b0; dvld = 1'b0; rdy = 1'b0;
    att = mk_tile(4, 0);
    #23;
    chk_idle_zero("rst");
    @(negedge clk);
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      chk("pre_busy", o_busy, 0);
      fill(vecs[i].pat, vecs[i].gap, NT);
      drain(vecs[i].pat, vecs[i].mode, vecs[i].ovf_row, vecs[i].inj_rdy);
      if (vecs[i].ovf_row >= 0) begin
        tick();
        chk("ovf_sticky", o_ovf, 1);
        head = 1'b1;
        tick();
        head = 1'b0;
        chk("ovf_clr", o_ovf, 0);
      end else begin
        chk("no_ovf", o_ovf, 0);
      end
      tick();
    end

    // Head abort after 5 tiles, with a tile offered in the same cycle.
    fill(2, 3, 5);
    att  = mk_tile(2, 5);
    dvld = 1'b1;
    head = 1'b1;
    tick();
    dvld = 1'b0;
    head = 1'b0;
    chk_idle_zero("abort");
    tick();
    chk("abort_busy2", o_busy, 0);
    fill(0, 3, NT);
    drain(0, 0, -1, 1'b0);

    // Sync clear while row 7 is presented.
    fill(1, 3, NT);
    rdy = 1'b1;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      chk("sc_idx", o_idx, r);
      tick();
    end
    @(negedge clk);
    chk("sc_idx7", o_idx, 7);
    chk_row("sc_row7", 1, 7);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    chk_idle_zero("sclr");
    tick();
    chk("sclr_done2", o_done, 0);
    chk("sclr_vld2",  o_vld,  0);

    // Async reset in the middle of a fill, between clock edges.
    fill(2, 1, 4);
    @(posedge clk);
    #3;
    chk("ar_busy_pre", o_busy, 1);
    arst_n = 1'b0;
    #1;
    chk_idle_zero("arst");
    #3;
    arst_n = 1'b1;
    tick();
    chk("ar_busy_post", o_busy, 0);
    fill(2, 3, NT);
    drain(2, 1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
